// File: rtl/mem_responder_pkg.sv
// Shared definitions for mem_responder: FSM state encodings, counter width
// and the legal LATENCY range.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_BUSY = 2'd1,
        MR_RESP = 2'd2
    } mr_state_t;

    localparam int CNT_W   = 4;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;

    function automatic int clamp_latency(input int lat);
        if (lat < LAT_MIN) return LAT_MIN;
        if (lat > LAT_MAX) return LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: synchronous 2^ADDR_WIDTH x 32 single-port RAM with write enable
// and a registered read port that holds its value between reads.
module mem_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_wr,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_wr) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Only the read register is reset; storage contents survive reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
        end else if (i_en && !i_wr) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder. Optional protocol-error output `err` is
// built when MEM_RESPONDER_ERR_EN is defined.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic        mem_re,
    input  logic        mem_wr,
    output logic [31:0] data_out,
`ifdef MEM_RESPONDER_ERR_EN
    output logic        mem_ready,
    output logic        err
`else
    output logic        mem_ready
`endif
);

    localparam int              LAT      = clamp_latency(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    mr_state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_ready;
    logic [31:0]           r_addr;
    logic [31:0]           r_data;
    logic                  r_wr;
    logic                  w_latch;
    logic                  w_acc_en;
    logic                  w_acc_wr;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [31:0]           w_acc_data;
    logic [31:0]           w_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MR_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == MR_RESP);
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_addr <= addr;
            r_data <= data_in;
            r_wr   <= mem_wr;
        end
    end

    // The array is touched only on the edge entering RESP, so a reset during
    // BUSY drops the request without writing. LATENCY=1 uses the live inputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_acc_en    = 1'b0;
        w_acc_wr    = r_wr;
        w_acc_addr  = r_addr[ADDR_WIDTH+1:2];
        w_acc_data  = r_data;
        case (r_state)
            MR_IDLE: begin
                if (mem_re || mem_wr) begin
                    w_latch = 1'b1;
                    if (LAT == 1) begin
                        w_state_nxt = MR_RESP;
                        w_acc_en    = 1'b1;
                        w_acc_wr    = mem_wr;
                        w_acc_addr  = addr[ADDR_WIDTH+1:2];
                        w_acc_data  = data_in;
                    end else begin
                        w_state_nxt = MR_BUSY;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            MR_BUSY: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = MR_RESP;
                    w_acc_en    = 1'b1;
                end
            end
            MR_RESP: w_state_nxt = MR_IDLE;
            default: w_state_nxt = MR_IDLE;
        endcase
    end

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem_array (
        .clk    (clk),
        .rst_n  (rst),
        .i_en   (w_acc_en),
        .i_wr   (w_acc_wr),
        .i_addr (w_acc_addr),
        .i_wdata(w_acc_data),
        .o_rdata(w_rdata)
    );

    assign data_out  = w_rdata;
    assign mem_ready = r_ready;

`ifdef MEM_RESPONDER_ERR_EN
    logic r_err;
    logic w_err_nxt;

    always_comb begin
        w_err_nxt = 1'b0;
        if (r_state == MR_IDLE) begin
            w_err_nxt = mem_re && mem_wr;
        end else if (r_state == MR_BUSY) begin
            w_err_nxt = (addr != r_addr) || (data_in != r_data) || (mem_wr != r_wr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign err = r_err;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{r_addr[31:ADDR_WIDTH+2], r_addr[1:0]};
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (LATENCY=4, ADDR_WIDTH=10); the err
// checks are built when MEM_RESPONDER_ERR_EN is defined.
module tb_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic        mem_re = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] data_out;
    logic        mem_ready;
`ifdef MEM_RESPONDER_ERR_EN
    logic        err;
`endif

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .mem_re   (mem_re),
        .mem_wr   (mem_wr),
        .data_out (data_out),
`ifdef MEM_RESPONDER_ERR_EN
        .mem_ready(mem_ready),
        .err      (err)
`else
        .mem_ready(mem_ready)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] dout;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    // Monitor: every mem_ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst && mem_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_ready: got pulse at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cyc == e.cyc) n_pass++;
                else $display("FAIL ready_cycle: got %0d expected %0d", cyc, e.cyc);
                n_checks++;
                if (data_out === e.dout) n_pass++;
                else $display("FAIL data_out: got 0x%08h expected 0x%08h", data_out, e.dout);
            end
        end
`ifdef MEM_RESPONDER_ERR_EN
        if (rst && err) err_cnt++;
`endif
    end

    task automatic wait_ready_and_release();
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                seen = 1;
                break;
            end
        end
        mem_re = 1'b0;
        mem_wr = 1'b0;
        if (!seen) begin
            n_checks++;
            $display("FAIL ready_timeout: got no pulse expected one within 40 cycles");
        end
    endtask

    task automatic do_req(input logic re, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_dout);
        @(negedge clk);
        mem_re  = re;
        mem_wr  = wr;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        q.push_back('{cyc: cyc + LAT - 1, dout: exp_dout});
        wait_ready_and_release();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_base;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, mem_ready}, 32'd0);
        check("reset_dout", data_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        do_req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0);
        do_req(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        check("dout_hold", data_out, 32'hDEADBEEF);

        do_req(1'b0, 1'b1, 32'h0, 32'h12345678, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h1000, 32'h0, 32'h12345678);
        do_req(1'b1, 1'b0, 32'h3, 32'h0, 32'h12345678);
        do_req(1'b0, 1'b1, 32'h44, 32'h1, 32'h12345678);

        // Back-to-back reads with mem_re held: second sampled 5 cycles after the first.
        @(negedge clk);
        mem_re = 1'b1;
        addr   = 32'h40;
        @(posedge clk);
        #1;
        q.push_back('{cyc: cyc + LAT - 1, dout: 32'hDEADBEEF});
        repeat (3) @(posedge clk);
        @(negedge clk);
        addr = 32'h44;
        repeat (2) @(posedge clk);
        #1;
        q.push_back('{cyc: cyc + LAT - 1, dout: 32'h1});
        wait_ready_and_release();

        do_req(1'b0, 1'b1, 32'h80, 32'h0BADF00D, 32'h1);

        // Reset during BUSY of a write: no pulse, no array update.
        @(negedge clk);
        mem_wr  = 1'b1;
        addr    = 32'h80;
        data_in = 32'hAAAA5555;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_ready", {31'd0, mem_ready}, 32'd0);
        check("midreset_dout", data_out, 32'd0);
        @(negedge clk);
        mem_wr = 1'b0;
        rst    = 1'b1;
        repeat (6) @(negedge clk);
        do_req(1'b1, 1'b0, 32'h80, 32'h0, 32'h0BADF00D);

`ifdef MEM_RESPONDER_ERR_EN
        err_base = err_cnt;
        @(negedge clk);
        mem_re  = 1'b1;
        mem_wr  = 1'b1;
        addr    = 32'h100;
        data_in = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        q.push_back('{cyc: cyc + LAT - 1, dout: 32'h0BADF00D});
        @(posedge clk);
        @(negedge clk);
        addr = 32'h104;
        @(negedge clk);
        addr = 32'h100;
        wait_ready_and_release();
        repeat (2) @(negedge clk);
        check("err_pulses", err_cnt - err_base, 32'd2);
        do_req(1'b1, 1'b0, 32'h100, 32'h0, 32'h5A5A5A5A);
`else
        err_base = 0;
`endif

        repeat (8) @(negedge clk);
        check("queue_drained", q.size() + err_base, 32'd0 + err_base);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
